// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg : mode encoding, stage-mapping and reference helpers for   |
// |             pipelined_shift_unit                                     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_op_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x, input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i[5:0]] = x[6'(n - 1 - i)];
    return r;
  endfunction

  // Register stage that hosts log level k.
  function automatic int stage_of(input int k, input int p, input int shw);
    return (k * p) / shw;
  endfunction

  function automatic int last_level(input int s, input int p, input int shw);
    int r;
    r = 0;
    for (int k = 0; k < shw; k++) if (stage_of(k, p, shw) == s) r = k;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] golden_shift(input logic [MAX_W-1:0] a, input int amt,
                                                    input shift_op_t op, input int n);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] am;
    logic [MAX_W-1:0] r;
    mask = (n >= MAX_W) ? '1 : ((64'd1 << n) - 64'd1);
    am   = a & mask;
    case (op)
      SH_SLL: r = (am << amt) & mask;
      SH_SRL: r = am >> amt;
      SH_SRA: begin
        r = am >> amt;
        if (am[6'(n - 1)]) r = r | (mask & ~(mask >> amt));
      end
      SH_ROL: r = (amt == 0) ? am : (((am << amt) | (am >> (n - amt))) & mask);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_level : one runtime-enabled log level, left shift by 2**K      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module shift_level
  import shift_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic [N-1:0] d,
  input  logic         en,
  input  shift_op_t    mode,
  input  logic         sign,
  output logic [N-1:0] q
);

  localparam int S = 1 << K;

  logic [S-1:0] fill;

  // Rotation refills with the bits leaving the top; SRA (bit-reversed) refills with the sign.
  always_comb begin
    fill = '0;
    if (mode == SH_ROL)      fill = d[N-1 -: S];
    else if (mode == SH_SRA) fill = {S{sign}};
  end

  assign q = en ? {d[N-S-1:0], fill} : d;

endmodule
`default_nettype wire

// File: rtl/pipelined_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_shift_unit : pipelined SLL/SRL/SRA/ROL barrel shifter with |
// |   valid/ready handshake. Define SHIFT_UNIT_FLAGS_EN for zero/cout.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter int N           = 32,
  parameter int SHW         = $clog2(N),
  parameter int PIPE_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] amt,
  input  logic [1:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef SHIFT_UNIT_FLAGS_EN
  output logic           zero,
  output logic           cout,
`endif
  output logic [N-1:0]   z
);

  localparam int P = PIPE_STAGES;

  logic [N-1:0]   d_r    [P];
  logic [SHW-1:0] amt_r  [P];
  shift_op_t      op_r   [P];
  logic           sign_r [P];
  logic           v_r    [P];

  logic [N-1:0]   s_d    [P];
  logic [SHW-1:0] s_amt  [P];
  shift_op_t      s_op   [P];
  logic           s_sign [P];
  logic           s_v    [P];
  logic [N-1:0]   d_next [P];

  logic [N-1:0]   lq     [SHW];
  logic           adv    [P+1];

  shift_op_t op_in;
  logic      right_in;
  logic      right_out;
  logic [N-1:0] entry_d;
  logic [N-1:0] exit_d;

  assign op_in    = shift_op_t'(op);
  assign right_in = (op_in == SH_SRL) || (op_in == SH_SRA);
  assign entry_d  = right_in ? N'(bit_reverse(MAX_W'(a), N)) : a;

  assign right_out = (s_op[P-1] == SH_SRL) || (s_op[P-1] == SH_SRA);
  assign exit_d    = right_out ? N'(bit_reverse(MAX_W'(lq[SHW-1]), N)) : lq[SHW-1];

  // A stage may advance when empty or when the stage after it advances.
  always_comb begin
    adv[P] = out_ready;
    for (int i = P - 1; i >= 0; i--) adv[i] = !v_r[i] || adv[i+1];
  end

  assign in_ready  = adv[0];
  assign out_valid = v_r[P-1];
  assign z         = d_r[P-1];

`ifdef SHIFT_UNIT_FLAGS_EN
  logic           s_cout [P];
  logic           cout_r [P];
  logic           zero_r;
  logic           cout_in;
  logic [SHW-1:0] lidx;
  logic [SHW-1:0] ridx;

  assign lidx    = SHW'(N - int'(amt));
  assign ridx    = amt - SHW'(1);
  assign cout_in = (amt == '0) ? 1'b0 :
                   ((op_in == SH_SLL) || (op_in == SH_ROL)) ? a[lidx] : a[ridx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  zero_r <= 1'b0;
    else if (adv[P-1] && s_v[P-1]) zero_r <= (d_next[P-1] == '0);
  end

  assign zero = zero_r;
  assign cout = cout_r[P-1];
`endif

  for (genvar i = 0; i < P; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign s_d[i]    = entry_d;
      assign s_amt[i]  = amt;
      assign s_op[i]   = op_in;
      assign s_sign[i] = a[N-1];
      assign s_v[i]    = in_valid;
`ifdef SHIFT_UNIT_FLAGS_EN
      assign s_cout[i] = cout_in;
`endif
    end else begin : g_body
      assign s_d[i]    = d_r[i-1];
      assign s_amt[i]  = amt_r[i-1];
      assign s_op[i]   = op_r[i-1];
      assign s_sign[i] = sign_r[i-1];
      assign s_v[i]    = v_r[i-1];
`ifdef SHIFT_UNIT_FLAGS_EN
      assign s_cout[i] = cout_r[i-1];
`endif
    end

    if (i == P - 1) begin : g_exit
      assign d_next[i] = exit_d;
    end else begin : g_mid
      assign d_next[i] = lq[last_level(i, P, SHW)];
    end

    // Payload only moves with a valid token so bubbles leave the data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r[i]    <= 1'b0;
        d_r[i]    <= '0;
        amt_r[i]  <= '0;
        op_r[i]   <= SH_SLL;
        sign_r[i] <= 1'b0;
`ifdef SHIFT_UNIT_FLAGS_EN
        cout_r[i] <= 1'b0;
`endif
      end else if (adv[i]) begin
        v_r[i] <= s_v[i];
        if (s_v[i]) begin
          d_r[i]    <= d_next[i];
          amt_r[i]  <= s_amt[i];
          op_r[i]   <= s_op[i];
          sign_r[i] <= s_sign[i];
`ifdef SHIFT_UNIT_FLAGS_EN
          cout_r[i] <= s_cout[i];
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_level
    localparam int ST = stage_of(k, P, SHW);
    logic [N-1:0] din;

    if ((k == 0) || (stage_of(k - 1, P, SHW) != ST)) begin : g_first
      assign din = s_d[ST];
    end else begin : g_chain
      assign din = lq[k-1];
    end

    shift_level #(.N(N), .K(k)) u_level (
      .d    (din),
      .en   (s_amt[ST][k]),
      .mode (s_op[ST]),
      .sign (s_sign[ST]),
      .q    (lq[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_shift_unit : scoreboard bench with a bitwise reference  |
// |   model; define SHIFT_UNIT_FLAGS_EN to also check zero/cout.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pipelined_shift_unit;
  import shift_pkg::*;

  localparam int N   = 32;
  localparam int SHW = 5;
  parameter  int PIPE_STAGES = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a = '0;
  logic [SHW-1:0] amt = '0;
  logic [1:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   z;
`ifdef SHIFT_UNIT_FLAGS_EN
  logic           zero;
  logic           cout;
`endif

  pipelined_shift_unit #(.N(N), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFT_UNIT_FLAGS_EN
    .zero      (zero),
    .cout      (cout),
`endif
    .z         (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] z;
    logic         zero;
    logic         cout;
    int           cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   stalled = 1'b0;
  logic [N-1:0] held_z = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Each result bit is taken straight from its source position in the operand.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int s, input int o);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) begin
      case (o)
        0:       r[j] = (j >= s) ? x[j-s] : 1'b0;
        1:       r[j] = (j + s < N) ? x[j+s] : 1'b0;
        2:       r[j] = (j + s < N) ? x[j+s] : x[N-1];
        default: r[j] = x[(j - s + N) % N];
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_cout(input logic [N-1:0] x, input int s, input int o);
    if (s == 0) return 1'b0;
    if (o == 0 || o == 3) return x[N-s];
    return x[s-1];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_hold_z", 64'(z), 64'(held_z));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got z=%0h expected no result", z);
        end else begin
          mon_e = sb.pop_front();
          check("z", 64'(z), 64'(mon_e.z));
`ifdef SHIFT_UNIT_FLAGS_EN
          check("zero", 64'(zero), 64'(mon_e.zero));
          check("cout", 64'(cout), 64'(mon_e.cout));
`endif
          if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.cyc), 64'(PIPE_STAGES));
        end
      end
      stalled = out_valid && !out_ready;
      held_z  = z;
    end
  end

  task automatic drive(input bit v, input logic [N-1:0] da, input int damt, input int dop,
                       input bit rdy, input bit use_z, input logic [N-1:0] cz, output bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = da;
    amt       = SHW'(damt);
    op        = 2'(dop);
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      e.z = ref_shift(da, damt, dop);
      check("golden_shift", golden_shift(64'(da), damt, shift_op_t'(dop), N), 64'(e.z));
      if (use_z) e.z = cz;
      e.zero    = (e.z == '0);
      e.cout    = ref_cout(da, damt, dop);
      e.cyc     = cyc;
      e.chk_lat = chk_lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    drive(1'b0, N'($urandom), int'($urandom_range(31)), int'($urandom_range(3)), rdy, 1'b0, '0, acc);
  endtask

  task automatic send(input logic [N-1:0] da, input int damt, input int dop, input int rdy_pct,
                      input bit use_z, input logic [N-1:0] cz);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc) begin
      drive(1'b1, da, damt, dop, ($urandom_range(99) < rdy_pct), use_z, cz, acc);
      n++;
      if (!acc && n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected an accept", n);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      idle(1'b1);
      n++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  logic [N-1:0] bp_a   [6];
  int           bp_amt [6];
  int           bp_op  [6];

  initial begin
    int idx;
    bit acc;
    logic [N-1:0] ra;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_z", 64'(z), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mode sweep and boundaries with a free-running output
    chk_lat = 1'b1;
    send(32'h8000_00F1, 4, 0, 100, 1'b1, 32'h0000_0F10);
    send(32'h8000_00F1, 4, 1, 100, 1'b1, 32'h0800_000F);
    send(32'h8000_00F1, 4, 2, 100, 1'b1, 32'hF800_000F);
    send(32'h8000_00F1, 4, 3, 100, 1'b1, 32'h0000_0F18);
    for (int m = 0; m < 4; m++) send(32'hA5A5_A5A5, 0, m, 100, 1'b1, 32'hA5A5_A5A5);
    send(32'hA5A5_A5A5, 31, 2, 100, 1'b1, 32'hFFFF_FFFF);
    send(32'hA5A5_A5A5, 31, 1, 100, 1'b1, 32'h0000_0001);
    send(32'hA5A5_A5A5, 31, 3, 100, 1'b1, 32'hD2D2_D2D2);
    drain();
    chk_lat = 1'b0;

    // Backpressure: six back-to-back inputs against a stalled output
    for (int i = 0; i < 6; i++) begin
      bp_a[i]   = N'($urandom);
      bp_amt[i] = int'($urandom_range(31));
      bp_op[i]  = int'($urandom_range(3));
    end
    idx = 0;
    for (int c = 0; c < PIPE_STAGES + 2; c++) begin
      drive(idx < 6, bp_a[idx % 6], bp_amt[idx % 6], bp_op[idx % 6], 1'b0, 1'b0, '0, acc);
      if (acc) idx++;
    end
    check("bp_accepts_when_full", 64'(idx), 64'(PIPE_STAGES));
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int c = 0; c < 50 && idx < 6; c++) begin
      drive(1'b1, bp_a[idx], bp_amt[idx], bp_op[idx], 1'b1, 1'b0, '0, acc);
      if (acc) idx++;
    end
    drain();

    // Reset with results in flight
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, N'($urandom), int'($urandom_range(31)), int'($urandom_range(3)), 1'b0, 1'b0, '0, acc);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_z", 64'(z), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (PIPE_STAGES + 5) idle(1'b1);

    // Random traffic with random stalls
    for (int i = 0; i < 2000; i++) begin
      while ($urandom_range(3) == 0) idle($urandom_range(99) < 70);
      ra = ($urandom_range(15) == 0) ? '0 : N'($urandom);
      send(ra, int'($urandom_range(31)), int'($urandom_range(3)), 70, 1'b0, '0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
